// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
// Holds the receive FSM state encoding plus the prescale and parity-type codes.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } rx_state_e;

    localparam logic [5:0] PRESC_8  = 6'd8;
    localparam logic [5:0] PRESC_16 = 6'd16;
    localparam logic [5:0] PRESC_32 = 6'd32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Anything other than 16 or 32 runs at 8x oversampling.
    function automatic logic [5:0] presc_sel(input logic [5:0] p);
        case (p)
            PRESC_16: presc_sel = PRESC_16;
            PRESC_32: presc_sel = PRESC_32;
            default:  presc_sel = PRESC_8;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial-line, configuration and received-word bundle of the UART receiver.
// The slave side is the receiver; the master side drives the line and config.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [5:0]            Prescale;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP, Prescale,
        input  P_DATA, data_valid, par_err, stp_err
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP, Prescale,
        output P_DATA, data_valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling timer and 3-point majority vote for the UART receiver.
// bit_done marks the last oversample edge of each bit, where decisions are made.
module uart_rx_sampler
    import uart_rx_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       rx_s,
    input  logic       en,
    input  logic [5:0] presc,
    output logic       bit_val,
    output logic       bit_done
);

    logic [5:0] edge_cnt;
    logic [5:0] last_edge;
    logic [5:0] mid;
    logic [2:0] smp;

    assign last_edge = presc - 6'd1;
    assign mid       = {1'b0, presc[5:1]};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            smp      <= '0;
        end else begin
            if (!en || edge_cnt == last_edge) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + 6'd1;
            end
            if (en) begin
                if (edge_cnt == mid - 6'd1) smp[0] <= rx_s;
                if (edge_cnt == mid)        smp[1] <= rx_s;
                if (edge_cnt == mid + 6'd1) smp[2] <= rx_s;
            end
        end
    end

    assign bit_val  = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
    assign bit_done = en && (edge_cnt == last_edge);

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: synchronizes the line, frames start/data/parity/stop
// and reports each frame with a one-cycle data_valid or error strobe.
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic     CLK,
    input  logic     RST,
    uart_rx_if.slave bus
);

    localparam int BCW = $clog2(DATA_WIDTH + 1);

    logic [1:0]            sync_q;
    logic                  rx_s;
    rx_state_e             state;
    logic [BCW-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic                  perr;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [5:0]            presc_q;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  data_valid_q;
    logic                  par_err_q;
    logic                  stp_err_q;
    logic                  smp_en;
    logic                  bit_val;
    logic                  bit_done;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[0], bus.RX_IN};
        end
    end

    assign rx_s = sync_q[1];

    // The detect cycle itself counts as oversample edge 0 of the start bit.
    always_comb begin
        smp_en = 1'b0;
        case (state)
            IDLE:                      smp_en = !rx_s;
            START, DATA, PARITY, STOP: smp_en = 1'b1;
            default:                   smp_en = 1'b0;
        endcase
    end

    uart_rx_sampler u_sampler (
        .CLK      (CLK),
        .RST      (RST),
        .rx_s     (rx_s),
        .en       (smp_en),
        .presc    (presc_q),
        .bit_val  (bit_val),
        .bit_done (bit_done)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shift        <= '0;
            perr         <= 1'b0;
            par_en_q     <= 1'b0;
            par_typ_q    <= PAR_EVEN;
            presc_q      <= PRESC_8;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (!rx_s) begin
                        par_en_q  <= bus.PAR_EN;
                        par_typ_q <= bus.PAR_TYP;
                        presc_q   <= presc_sel(bus.Prescale);
                        perr      <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state <= bit_val ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        shift   <= {bit_val, shift[DATA_WIDTH-1:1]};
                        bit_cnt <= bit_cnt + BCW'(1);
                        if (bit_cnt == BCW'(DATA_WIDTH - 1)) begin
                            state <= par_en_q ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        perr  <= bit_val ^ (^shift) ^ (par_typ_q == PAR_ODD);
                        state <= STOP;
                    end
                end
                STOP: begin
                    // Strobes are registered on entry so they are high during DONE.
                    if (bit_done) begin
                        if (perr || !bit_val) begin
                            par_err_q <= perr;
                            stp_err_q <= !bit_val;
                        end else begin
                            data_valid_q <= 1'b1;
                            p_data_q     <= shift;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.P_DATA     = p_data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.par_err    = par_err_q;
    assign bus.stp_err    = stp_err_q;

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
UART receive engine, the receive-side counterpart of the UART_TX serializer path. It oversamples the asynchronous serial line, detects the start bit, and reconstructs the frame: start, DATA_WIDTH data bits LSB-first, optional parity, one stop bit. It then delivers the parallel word with a one-cycle valid strobe and error flags. It sits in the UART_RX path, clocked by the UART RX clock domain, feeding the system controller.

Parameters:
DATA_WIDTH, 8, number of data bits per frame.

Ports:
CLK  input  1  UART RX clock, Prescale times the bit rate.
RST  input  1  asynchronous, active-low reset.
RX_IN  input  1  serial line, idle high, asynchronous to CLK.
PAR_EN  input  1  1 = parity bit present.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
Prescale  input  6  oversampling ratio; legal values 8, 16, 32.
P_DATA  output  DATA_WIDTH  last good received word.
data_valid  output  1  one-cycle strobe; P_DATA updated this cycle.
par_err  output  1  one-cycle strobe; parity mismatch.
stp_err  output  1  one-cycle strobe; stop bit sampled 0.

Behaviour:
- Reset (RST low, asynchronous): all outputs 0 (P_DATA 0), FSM to IDLE, counters 0, synchronizer flops 1. Reset mid-frame aborts the frame with no flags.
- RX_IN passes through a 2-flop synchronizer (rx_s). All timing below is relative to rx_s, which lags RX_IN by 2 cycles.
- Config latch: PAR_EN, PAR_TYP and Prescale are latched on start detection and held for the frame. A Prescale value other than 16 or 32 is treated as 8.
- Timing counters:
  - edge_cnt counts 0..P-1 within each bit; it wraps to 0 at P-1.
  - bit_cnt increments on each wrap.
  - The start-detect cycle is edge 0 of the start bit.
- Sampling:
  - rx_s is sampled at edges P/2-1, P/2 and P/2+1.
  - The bit value is the majority of the 3 samples, valid from edge P/2+2.
  - All bit decisions are made at edge P-1.
- FSM states:
  - IDLE: rx_s==0 goes to START.
  - START: at edge P-1, sampled 0 goes to DATA; sampled 1 is a glitch and returns to IDLE with no outputs.
  - DATA: shifts sampled bits into a shift register, LSB first. After DATA_WIDTH bits, goes to PARITY if PAR_EN, else STOP.
  - PARITY: expected bit = XOR of data bits, inverted if PAR_TYP=1. A mismatch sets the internal perr flag. Goes to STOP.
  - STOP: at edge P-1, records serr = (sample==0). Goes to DONE.
  - DONE: single cycle; outputs are registered here, then goes to IDLE.
- DONE outputs:
  - No errors: data_valid=1 and P_DATA is loaded from the shift register.
  - Errors: par_err and/or stp_err = 1, data_valid=0, P_DATA unchanged.
  - Both errors may assert together.
- Latency: with N = 10 + PAR_EN bits and D = start-detect cycle, the strobes are high during cycle D+N*P and are low otherwise.
- Back-to-back frames: IDLE follows DONE. A falling rx_s in that IDLE cycle starts the next frame immediately, giving one cycle of slack per frame.
- rx_s low during DONE is ignored; it is re-checked in IDLE.
- A line held low (break): each START decision sees 0, so the frame proceeds and ends with stp_err. The FSM then re-arms.

Decomposition:
- Package uart_rx_pkg:
  - FSM state enum: IDLE, START, DATA, PARITY, STOP, DONE.
  - Prescale constants: PRESC_8, PRESC_16, PRESC_32.
  - Parity-type constants: PAR_EVEN=0, PAR_ODD=1.
- Sub-module uart_rx_sampler: edge_cnt, the 3-sample majority vote and the bit_done pulse at edge P-1. It takes the latched Prescale and an enable from the FSM.
- The FSM, shift register, parity and stop checks stay in uart_rx_core.

Test Plan:
- Directed frame, P=8, PAR_EN=0, frame 0xA5 (line 0,1,0,1,0,0,1,0,1,1) -> data_valid one cycle at D+80, P_DATA=0xA5, no error flags.
- P=16, PAR_EN=1, PAR_TYP=0, data 0x3C, parity bit 1 -> par_err pulse at D+176, data_valid=0, P_DATA keeps its previous value. Parity bit 0 -> data_valid, P_DATA=0x3C.
- P=8, PAR_TYP=1, data 0x01, correct parity 0 but stop bit 0 -> stp_err only, at D+88.
- Glitch: P=16, RX_IN low for 3 cycles then high -> FSM returns to IDLE at edge 15, no strobes. A following valid frame 0x5A is received correctly.
- Back-to-back: P=32, frames 0x55 then 0xAA with zero idle gap -> two data_valid strobes 321 cycles apart, P_DATA=0x55 then 0xAA.
- Reset mid-frame: RST low at data bit 4 of a frame -> all outputs 0 immediately, no strobe. The next frame 0xFF is received correctly after reset release.
